// File: rtl/rr_merge2.sv
// ----------------------------------------------------------------------------
// rr_merge2 : two-input round-robin stream merger with a registered output.
//
// Merges two independent valid/ready producers (A and B) into one ordered
// stream at one beat per cycle. When both sources are valid, the source not
// granted last time wins. The output register carries the payload and its
// origin (y_src), which selects the downstream 2:1 stage.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   a_valid/a_ready  source A handshake, a_data payload
//   b_valid/b_ready  source B handshake, b_data payload
//   y_valid/y_ready  output handshake, y_data payload, y_src origin (0=A,1=B)
//   cnt_a, cnt_b     wrapping counts of beats accepted from A and B
// ----------------------------------------------------------------------------
module rr_merge2 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_src,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    logic             r_y_valid;
    logic [WIDTH-1:0] r_y_data;
    logic             r_y_src;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;
    logic             r_prio;     // 0: A preferred on a tie, 1: B preferred

    logic             w_accept;
    logic             w_gnt_a;
    logic             w_gnt_b;

    // Output register can take a beat when empty or draining this cycle.
    assign w_accept = !r_y_valid || y_ready;

    // A wins if it is alone, or on a tie while A holds priority; B symmetric.
    assign w_gnt_a = a_valid && (!b_valid || !r_prio);
    assign w_gnt_b = b_valid && (!a_valid ||  r_prio);

    assign a_ready = w_accept && w_gnt_a;
    assign b_ready = w_accept && w_gnt_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
            r_y_src   <= 1'b0;
            r_cnt_a   <= '0;
            r_cnt_b   <= '0;
            r_prio    <= 1'b0;
        end else if (w_accept) begin
            if (w_gnt_a) begin
                r_y_valid <= 1'b1;
                r_y_data  <= a_data;
                r_y_src   <= 1'b0;
                r_prio    <= 1'b1;
                r_cnt_a   <= r_cnt_a + 1'b1;
            end else if (w_gnt_b) begin
                r_y_valid <= 1'b1;
                r_y_data  <= b_data;
                r_y_src   <= 1'b1;
                r_prio    <= 1'b0;
                r_cnt_b   <= r_cnt_b + 1'b1;
            end else begin
                // Drain with nothing to load: payload and origin are kept.
                r_y_valid <= 1'b0;
            end
        end
    end

    assign y_valid = r_y_valid;
    assign y_data  = r_y_data;
    assign y_src   = r_y_src;
    assign cnt_a   = r_cnt_a;
    assign cnt_b   = r_cnt_b;

endmodule

// File: tb/tb_rr_merge2.sv
module tb_rr_merge2;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             a_valid, b_valid, y_ready;
    logic [WIDTH-1:0] a_data, b_data;
    logic             a_ready, b_ready, y_valid, y_src;
    logic [WIDTH-1:0] y_data;
    logic [CNT_W-1:0] cnt_a, cnt_b;

    always #5 clk = ~clk;

    rr_merge2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_src(y_src),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Scoreboard of beats the merger must emit, in order: {src, data}.
    logic [WIDTH:0] exp_q[$];

    // Reference model: which source gets in follows only from the fairness
    // rule (last winner yields on a tie) and whether the output slot is free.
    bit             m_full;
    bit             m_pref_b;
    int             m_cnt[2];
    logic [WIDTH:0] m_last;
    // Model state as it should appear after the most recent clock edge.
    bit             v_full;
    int             v_cnt[2];
    logic [WIDTH:0] v_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full = 0; m_pref_b = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_last = '0;
        v_full = 0; v_cnt[0] = 0; v_cnt[1] = 0; v_last = '0;
        exp_q.delete();
    endtask

    // One clock cycle: drive inputs 2 after the edge, then predict and check
    // the combinational readies and record what the next edge will load.
    task automatic cycle(input bit av, input logic [WIDTH-1:0] ad,
                         input bit bv, input logic [WIDTH-1:0] bd, input bit yr);
        bit space;
        int who;
        @(posedge clk);
        v_full = m_full; v_cnt = m_cnt; v_last = m_last;
        #2;
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
        #1;
        space = !m_full || yr;
        if (av && bv)  who = m_pref_b ? 1 : 0;
        else if (av)   who = 0;
        else if (bv)   who = 1;
        else           who = -1;
        chk("a_ready", {31'd0, a_ready}, {31'd0, space && who == 0});
        chk("b_ready", {31'd0, b_ready}, {31'd0, space && who == 1});
        if (space) begin
            if (who >= 0) begin
                m_last = (who == 0) ? {1'b0, ad} : {1'b1, bd};
                exp_q.push_back(m_last);
                m_pref_b = (who == 0);
                m_cnt[who] = (m_cnt[who] + 1) % (1 << CNT_W);
                m_full = 1;
            end else begin
                m_full = 0;
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_y_valid"}, {31'd0, y_valid}, 32'd0);
        chk({tag, "_y_data"},  {24'd0, y_data},  32'd0);
        chk({tag, "_y_src"},   {31'd0, y_src},   32'd0);
        chk({tag, "_cnt_a"},   {24'd0, cnt_a},   32'd0);
        chk({tag, "_cnt_b"},   {24'd0, cnt_b},   32'd0);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        a_valid = 0; b_valid = 0; y_ready = 0; a_data = '0; b_data = '0;
        #1;
        chk_zero(tag);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares the visible output against the model every cycle and
    // pops the scoreboard on every output handshake.
    initial begin
        logic [WIDTH:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("mon_y_valid", {31'd0, y_valid}, {31'd0, v_full});
                chk("mon_y_last",  {23'd0, y_src, y_data}, {23'd0, v_last});
                chk("mon_cnt_a",   {24'd0, cnt_a}, v_cnt[0]);
                chk("mon_cnt_b",   {24'd0, cnt_b}, v_cnt[1]);
                if (y_valid === 1'b1 && y_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_beat", {23'd0, y_src, y_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_beat", {23'd0, y_src, y_data}, {23'd0, e});
                    end
                end
            end
        end
    end

    initial begin
        logic [CNT_W-1:0] ca, cb;
        logic [WIDTH-1:0] d;
        rst_n = 1'b0;
        a_valid = 0; b_valid = 0; y_ready = 0; a_data = '0; b_data = '0;
        model_reset();
        #12;
        chk_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: reset while a beat is held, then first transfer after release
        cycle(1, 8'h77, 0, 8'h00, 0);
        cycle(1, 8'h78, 0, 8'h00, 0);
        chk("t1_pre_valid", {31'd0, y_valid}, 32'd1);
        do_reset("t1_rst");
        cycle(1, 8'h5A, 0, 8'h00, 1);
        chk("t1_a_ready", {31'd0, a_ready}, 32'd1);
        cycle(0, 8'h00, 0, 8'h00, 1);
        chk("t1_y_valid", {31'd0, y_valid}, 32'd1);
        chk("t1_y_data",  {24'd0, y_data},  32'h5A);
        chk("t1_y_src",   {31'd0, y_src},   32'd0);
        chk("t1_cnt_a",   {24'd0, cnt_a},   32'd1);

        // 2: strict alternation with both sources valid
        do_reset("t2_rst");
        cycle(1, 8'h11, 1, 8'h22, 1);
        for (int i = 0; i < 6; i++) begin
            if (i < 5) cycle(1, 8'h11, 1, 8'h22, 1);
            else       cycle(0, 8'h00, 1, 8'h33, 1);
            chk("t2_y_src",  {31'd0, y_src},  i % 2);
            chk("t2_y_data", {24'd0, y_data}, (i % 2) ? 32'h22 : 32'h11);
        end
        // The last cycle above granted B once more (0x33) for test 3.
        chk("t2_cnt_a", {24'd0, cnt_a}, 32'd3);
        chk("t2_cnt_b", {24'd0, cnt_b}, 32'd3);

        // 3: backpressure holds the B beat and blocks both sources
        for (int i = 0; i < 4; i++) begin
            cycle(1, 8'h11, 1, 8'h22, 0);
            chk("t3_a_ready", {31'd0, a_ready}, 32'd0);
            chk("t3_b_ready", {31'd0, b_ready}, 32'd0);
            chk("t3_y_data",  {24'd0, y_data},  32'h33);
            chk("t3_y_src",   {31'd0, y_src},   32'd1);
        end
        cycle(1, 8'h11, 1, 8'h22, 1);
        chk("t3_a_wins", {31'd0, a_ready}, 32'd1);

        // 4: drain to empty keeps payload, counters still
        ca = cnt_a; cb = cnt_b;
        cycle(0, 8'h00, 0, 8'h00, 1);
        chk("t3_y_data_next", {24'd0, y_data}, 32'h11);
        chk("t3_y_src_next",  {31'd0, y_src},  32'd0);
        cycle(0, 8'h00, 0, 8'h00, 1);
        chk("t4_y_valid", {31'd0, y_valid}, 32'd0);
        chk("t4_y_data",  {24'd0, y_data},  32'h11);
        chk("t4_cnt_a",   {24'd0, cnt_a},   {24'd0, ca + 8'd1});
        chk("t4_cnt_b",   {24'd0, cnt_b},   {24'd0, cb});

        // 5: 256 A beats wrap the A counter back to its start value
        ca = cnt_a; cb = cnt_b;
        for (int i = 0; i < 256; i++) begin
            d = WIDTH'($urandom);
            cycle(1, d, 0, 8'h00, 1);
        end
        cycle(0, 8'h00, 0, 8'h00, 1);
        chk("t5_cnt_a", {24'd0, cnt_a}, {24'd0, ca});
        chk("t5_cnt_b", {24'd0, cnt_b}, {24'd0, cb});

        // 6: a lone A grant hands priority to B
        do_reset("t6_rst");
        cycle(1, 8'hA1, 0, 8'h00, 1);
        cycle(1, 8'hA2, 1, 8'hB2, 1);
        chk("t6_b_ready", {31'd0, b_ready}, 32'd1);
        chk("t6_a_ready", {31'd0, a_ready}, 32'd0);
        cycle(0, 8'h00, 0, 8'h00, 1);
        chk("t6_y_src",  {31'd0, y_src},  32'd1);
        chk("t6_y_data", {24'd0, y_data}, 32'hB2);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 4) != 0, WIDTH'($urandom),
                  ($urandom % 3) != 0, WIDTH'($urandom),
                  ($urandom % 4) != 0);
        end
        cycle(0, 8'h00, 0, 8'h00, 1);
        cycle(0, 8'h00, 0, 8'h00, 1);
        cycle(0, 8'h00, 0, 8'h00, 1);
        @(negedge clk);
        chk("sb_leftover", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
